// File: rtl/music_pkg.sv
// music_pkg: shared state type, command bytes and duration table for the music sequencer
package music_pkg;
  localparam int TONE_W = 5;
  localparam int DUR_W = 3;
  localparam int MS_W = 16;
  localparam logic [7:0] CMD_PLAY = 8'hF0;
  localparam logic [7:0] CMD_STOP = 8'hF1;
  localparam logic [7:0] CMD_PAUSE = 8'hF2;
  localparam logic [7:0] CMD_LOAD = 8'hF3;
  localparam logic [7:0] CMD_END = 8'hFF;
  localparam logic [MS_W-1:0] DUR_MS [8] = '{16'd0, 16'd200, 16'd500, 16'd1000, 16'd2000, 16'd4000, 16'd100, 16'd50};
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, NOTE, GAP, PAUSE} state_t;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: clearable, freezable prescaler emitting a one-cycle tick every millisecond
module ms_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int DIV = CLK_FREQ_HZ / 1000;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/music_seq_player.sv
// music_seq_player: UART-loaded note sequencer with pause, stop and loop playback
module music_seq_player
  import music_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEPTH = 128,
  parameter int GAP_MS = 20
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic rx_valid,
  input  logic [7:0] rx_data,
  input  logic loop_en,
  output logic [TONE_W-1:0] tone_code,
  output logic tone_valid,
  output logic busy,
  output logic [$clog2(DEPTH)-1:0] play_idx,
  output logic [$clog2(DEPTH):0] song_len,
  output logic load_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t state, state_n;
  logic f_ph, ret_gap, tick, clr, en, expire, last, we;
  logic is_note, c_play, c_stop, c_pause, c_load, c_end;
  logic [AW-1:0] idx_n;
  logic [TONE_W-1:0] cur_tone;
  logic [DUR_W-1:0] cur_dur;
  logic [MS_W-1:0] ms_cnt, target;
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data;
  assign is_note = rx_valid && rx_data[7:3] <= 5'd29;
  assign c_play = rx_valid && rx_data == CMD_PLAY;
  assign c_stop = rx_valid && rx_data == CMD_STOP;
  assign c_pause = rx_valid && rx_data == CMD_PAUSE;
  assign c_load = rx_valid && rx_data == CMD_LOAD;
  assign c_end = rx_valid && rx_data == CMD_END;
  // a command cycle does not count as elapsed time, so a coincident expiry is discarded
  assign en = (state == NOTE || state == GAP) && !(c_stop || c_pause || c_load);
  assign target = state == GAP ? MS_W'(GAP_MS) : DUR_MS[cur_dur];
  assign expire = tick && ms_cnt == target - MS_W'(1);
  assign last = (AW+1)'(play_idx) + (AW+1)'(1) >= song_len;
  assign we = !sys_rst && state == LOAD && is_note && song_len != FULL;
  assign tone_code = state == NOTE ? cur_tone : '0;
  assign tone_valid = state == NOTE && cur_tone != '0;
  assign busy = state != IDLE;
  ms_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clr(clr),
    .en(en),
    .tick(tick)
  );
  always_comb begin
    state_n = state;
    idx_n = play_idx;
    clr = 1'b0;
    case (state)
      IDLE: begin
        state_n = c_load ? LOAD : (c_play && song_len != '0) ? FETCH : IDLE;
        idx_n = c_play ? '0 : play_idx;
      end
      LOAD: state_n = c_end ? IDLE : LOAD;
      default:
        if (c_load || c_stop) state_n = c_load ? LOAD : IDLE;
        else if (state == PAUSE) state_n = c_pause ? (ret_gap ? GAP : NOTE) : PAUSE;
        else if (c_pause && state != FETCH) state_n = PAUSE;
        else if (state == FETCH && f_ph) begin
          clr = 1'b1;
          state_n = rd_data[2:0] != '0 ? NOTE : loop_en ? FETCH : IDLE;
          idx_n = rd_data[2:0] != '0 ? play_idx : '0;
        end else if (expire) begin
          clr = 1'b1;
          state_n = (state == NOTE && GAP_MS != 0) ? GAP : (!last || loop_en) ? FETCH : IDLE;
          idx_n = (state == NOTE && GAP_MS != 0) ? play_idx : last ? '0 : play_idx + AW'(1);
        end
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      f_ph <= 1'b0;
      ret_gap <= 1'b0;
      play_idx <= '0;
      song_len <= '0;
      load_err <= 1'b0;
      ms_cnt <= '0;
      cur_tone <= '0;
      cur_dur <= '0;
    end else begin
      state <= state_n;
      f_ph <= state == FETCH && !f_ph && state_n == FETCH;
      play_idx <= idx_n;
      load_err <= state == LOAD && is_note && song_len == FULL;
      ms_cnt <= clr ? '0 : tick ? ms_cnt + MS_W'(1) : ms_cnt;
      if (state_n == LOAD && state != LOAD) song_len <= '0;
      else if (we) song_len <= song_len + (AW+1)'(1);
      if (state == FETCH && f_ph) {cur_tone, cur_dur} <= rd_data;
      if (state_n == PAUSE && state != PAUSE) ret_gap <= state == GAP;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (we) mem[song_len[AW-1:0]] <= rx_data;
    rd_data <= mem[play_idx];
  end
endmodule

// File: doc/music_seq_player.md
MUSIC_SEQ_PLAYER -- requirements
Module: music_seq_player

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter DEPTH, default 128, note memory depth in entries, at least 2.
REQ-003 SHALL have parameter GAP_MS, default 20, silent gap between notes in ms, at least 0.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking a received UART byte.
REQ-007 SHALL have port rx_data, input, 8 bits: the received byte, valid when rx_valid=1.
REQ-008 SHALL have port loop_en, input, 1 bit: 1 means repeat the song at its end; 0 means stop at its end.
REQ-009 SHALL have port tone_code, output, 5 bits: current tone index; 0 means silence.
REQ-010 SHALL have port tone_valid, output, 1 bit: 1 while a non-rest note sounds.
REQ-011 SHALL have port busy, output, 1 bit: 1 in every state other than IDLE.
REQ-012 SHALL have port play_idx, output, clog2(DEPTH) bits: index of the current note.
REQ-013 SHALL have port song_len, output, clog2(DEPTH)+1 bits: number of stored notes.
REQ-014 SHALL have port load_err, output, 1 bit: one-cycle pulse on a load overflow.

Function
REQ-015 SHALL decode each rx_valid byte as follows:
- bits[7:3] in 0..29: note byte {tone[4:0], dur[2:0]}.
- 0xF0: PLAY.
- 0xF1: STOP.
- 0xF2: PAUSE toggle.
- 0xF3: LOAD start.
- 0xFF: LOAD end.
- all other bytes with bits[7:3] of 30 or 31: ignored.
REQ-016 SHALL map duration codes to ms as: 1=200, 2=500, 3=1000, 4=2000, 5=4000, 6=100, 7=50; code 0 marks end-of-song.
REQ-017 SHALL implement the states IDLE, LOAD, FETCH, NOTE, GAP and PAUSE.
REQ-018 SHALL, in IDLE, enter LOAD on 0xF3, and on 0xF0 enter FETCH with play_idx=0 if song_len>0; otherwise it SHALL stay in IDLE.
REQ-019 SHALL, on 0xF3, clear song_len; LOAD SHALL then write each note byte at address song_len and increment song_len.
REQ-020 SHALL, in LOAD with song_len=DEPTH, drop further note bytes and pulse load_err once per dropped byte.
REQ-021 SHALL treat 0xFF as the only way to leave LOAD (to IDLE) and SHALL ignore all other command bytes while in LOAD.
REQ-022 SHALL use a synchronous-read memory: FETCH lasts exactly 2 cycles (address, then data), after which the block enters NOTE.
REQ-023 SHALL, when the fetched dur is 0, treat the note as end-of-song.
REQ-024 SHALL, in NOTE, set tone_code=tone and tone_valid=(tone!=0), and hold both for exactly dur_ms*(CLK_FREQ_HZ/1000) cycles.
REQ-025 SHALL clear the ms prescaler on entry to NOTE and on entry to GAP, so that durations are cycle-exact.
REQ-026 SHALL, in GAP, drive tone_code=0 and tone_valid=0 for GAP_MS ms, and SHALL skip GAP entirely when GAP_MS=0.
REQ-027 SHALL, after GAP, advance to play_idx+1 and FETCH when play_idx+1<song_len; otherwise this is end-of-song.
REQ-028 SHALL, at end-of-song, go to FETCH at index 0 when loop_en=1, else go to IDLE; loop_en SHALL be sampled at that cycle.
REQ-029 SHALL, on 0xF2 in NOTE or GAP, enter PAUSE, silence the outputs, and freeze the ms and duration counters.
REQ-030 SHALL, on 0xF2 in PAUSE, resume the frozen state with its remaining time intact; 0xF2 in any other state SHALL be ignored.
REQ-031 SHALL, on 0xF1 in FETCH, NOTE, GAP or PAUSE, enter IDLE on the next cycle with outputs silenced; the memory contents and song_len SHALL be kept.
REQ-032 SHALL, on 0xF3 while playing or paused, abort playback and enter LOAD.
REQ-033 SHALL ignore 0xF0 while playback is already active.
REQ-034 SHALL ignore rx_valid=0 cycles entirely.
REQ-035 SHALL process a byte arriving in the same cycle as a duration expiry first: the command wins, and the expiry is discarded.

Reset
REQ-036 SHALL, on reset, set state=IDLE, tone_code=0, tone_valid=0, busy=0, play_idx=0, song_len=0, load_err=0, and clear all counters.
REQ-037 SHALL let reset override any concurrent rx_valid; the memory contents SHALL be left uninitialised and unused because song_len=0.
REQ-038 SHALL, on reset mid-note, silence the outputs on the cycle after reset is sampled.

Structure
REQ-039 SHALL place the following in a shared package music_pkg: the state enum, the command byte constants, the duration-code-to-ms table, and TONE_W=5 / DUR_W=3.
REQ-040 SHALL instantiate one sub-module, ms_tick_gen, a clearable and freezable prescaler producing a one-cycle 1 ms tick.
REQ-041 SHALL hold the note memory as an inferable DEPTH x 8 synchronous RAM.

Verification
REQ-042 SHALL cover the following directed scenarios, all with CLK_FREQ_HZ=10_000 (10 clk/ms) and GAP_MS=2:
- Load and play: load F3,{5,1},{0,7},FF, then F0 -> tone 5 for 2000 cycles, silent gap 20 cycles, rest 500 cycles tone_valid=0, then idle with loop_en=0.
- Loop: same song with loop_en=1 -> play_idx wraps 1->0 and the second pass is timing-identical.
- Overflow: DEPTH=4, load 6 notes -> song_len=4 and exactly 2 load_err pulses.
- Pause: F2 at 300 cycles into a 2000-cycle note, F2 again 50 cycles later -> the note ends at 2051 cycles plus the FETCH offset, and it is silent while paused.
- Stop and reset: F1 mid-note -> IDLE and silent in 1 cycle, song_len kept; sys_rst mid-note -> all outputs 0.
- Corner cases: F0 with song_len=0 -> stays IDLE; an in-song note with dur=0 -> treated as end-of-song.
